// File: rtl/jogo_sequencia_param.sv
// Sequence-memory game engine: LFSR-generated sequence, growing replay on LEDs, press checking with timeout.
// Optional press echo on the LEDs while waiting/comparing is enabled by defining JOGO_ECO_EN.
module jogo_sequencia_param #(
  parameter int N_BOTOES       = 4,
  parameter int PROF           = 16,
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int LED_CICLOS     = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [15:0]         semente,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] leds,
  output logic                pronto,
  output logic                ganhou,
  output logic                perdeu,
  output logic                timeout,
  output logic [6:0]          rodada_atual,
  output logic [3:0]          db_estado
);

  localparam int IW = (PROF > 1) ? $clog2(PROF) : 1;
  localparam int LW = $clog2(LED_CICLOS + 1);
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    GERA        = 4'h1,
    MOSTRA      = 4'h2,
    ESPERA      = 4'h3,
    COMPARA     = 4'h4,
    PROX_JOGADA = 4'h5,
    PROX_RODADA = 4'h6,
    FIM_ACERTO  = 4'hA,
    FIM_ERRO    = 4'hE,
    FIM_TIMEOUT = 4'hD
  } estado_t;

  estado_t             estado_q, estado_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       rodada_q, rodada_d;
  logic [IW-1:0]       jogada_q, jogada_d;
  logic [IW-1:0]       k_q, k_d;
  logic                fase_q, fase_d;
  logic [LW-1:0]       led_cnt_q, led_cnt_d;
  logic [TW-1:0]       t_cnt_q, t_cnt_d;
  logic [N_BOTOES-1:0] captura_q, captura_d;
  logic [N_BOTOES-1:0] botoes_ant_q;
  logic                pronto_q, pronto_d;
  logic                ganhou_q, ganhou_d;
  logic                perdeu_q, perdeu_d;
  logic                timeout_q, timeout_d;

  logic [N_BOTOES-1:0] mem_q [PROF];
  logic                mem_we;

  logic [15:0]         lfsr_prox;
  logic [15:0]         semente_ef;
  logic [N_BOTOES-1:0] elem_novo;
  logic                aperto;

  function automatic logic [N_BOTOES-1:0] para_one_hot(input logic [2:0] v);
    int idx;
    idx = int'(v) % N_BOTOES;
    return {{(N_BOTOES-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign lfsr_prox  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign semente_ef = (semente == 16'h0000) ? 16'hACE1 : semente;
  assign elem_novo  = para_one_hot(lfsr_prox[2:0]);
  // A press is the first nonzero sample after an all-released cycle.
  assign aperto     = (botoes != '0) && (botoes_ant_q == '0);

  always_comb begin
    estado_d  = estado_q;
    lfsr_d    = lfsr_q;
    ptr_d     = ptr_q;
    rodada_d  = rodada_q;
    jogada_d  = jogada_q;
    k_d       = '0;
    fase_d    = 1'b0;
    led_cnt_d = '0;
    t_cnt_d   = t_cnt_q;
    captura_d = captura_q;
    pronto_d  = 1'b0;
    ganhou_d  = 1'b0;
    perdeu_d  = 1'b0;
    timeout_d = 1'b0;
    mem_we    = 1'b0;

    case (estado_q)
      INICIAL: begin
        if (iniciar) begin
          estado_d = GERA;
          lfsr_d   = semente_ef;
          rodada_d = '0;
          ptr_d    = '0;
        end
      end
      GERA: begin
        lfsr_d = lfsr_prox;
        mem_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == IW'(PROF - 1)) begin
          ptr_d    = '0;
          estado_d = MOSTRA;
        end
      end
      MOSTRA: begin
        k_d       = k_q;
        fase_d    = fase_q;
        led_cnt_d = led_cnt_q + 1'b1;
        if (led_cnt_q == LW'(LED_CICLOS - 1)) begin
          led_cnt_d = '0;
          fase_d    = ~fase_q;
          if (fase_q) begin
            if (k_q == rodada_q) begin
              estado_d = ESPERA;
              jogada_d = '0;
              t_cnt_d  = '0;
            end else begin
              k_d = k_q + 1'b1;
            end
          end
        end
      end
      ESPERA: begin
        t_cnt_d = t_cnt_q + 1'b1;
        if (aperto) begin
          captura_d = botoes;
          estado_d  = COMPARA;
        end else if (t_cnt_q == TW'(TIMEOUT_CICLOS - 1)) begin
          estado_d = FIM_TIMEOUT;
        end
      end
      COMPARA: begin
        if (captura_q != mem_q[jogada_q]) begin
          estado_d = FIM_ERRO;
        end else if (jogada_q != rodada_q) begin
          jogada_d = jogada_q + 1'b1;
          t_cnt_d  = '0;
          estado_d = PROX_JOGADA;
        end else begin
          estado_d = PROX_RODADA;
        end
      end
      PROX_JOGADA: begin
        t_cnt_d = '0;
        if (botoes == '0) estado_d = ESPERA;
      end
      PROX_RODADA: begin
        if (rodada_q == IW'(PROF - 1)) begin
          estado_d = FIM_ACERTO;
        end else if (botoes == '0) begin
          rodada_d = rodada_q + 1'b1;
          estado_d = MOSTRA;
        end
      end
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
        if (iniciar) begin
          estado_d = GERA;
          lfsr_d   = semente_ef;
          rodada_d = '0;
          ptr_d    = '0;
        end else begin
          pronto_d  = 1'b1;
          ganhou_d  = (estado_q == FIM_ACERTO);
          perdeu_d  = (estado_q != FIM_ACERTO);
          timeout_d = (estado_q == FIM_TIMEOUT);
        end
      end
      default: estado_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q     <= INICIAL;
      lfsr_q       <= '0;
      ptr_q        <= '0;
      rodada_q     <= '0;
      jogada_q     <= '0;
      k_q          <= '0;
      fase_q       <= 1'b0;
      led_cnt_q    <= '0;
      t_cnt_q      <= '0;
      captura_q    <= '0;
      botoes_ant_q <= '0;
      pronto_q     <= 1'b0;
      ganhou_q     <= 1'b0;
      perdeu_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      lfsr_q       <= lfsr_d;
      ptr_q        <= ptr_d;
      rodada_q     <= rodada_d;
      jogada_q     <= jogada_d;
      k_q          <= k_d;
      fase_q       <= fase_d;
      led_cnt_q    <= led_cnt_d;
      t_cnt_q      <= t_cnt_d;
      captura_q    <= captura_d;
      botoes_ant_q <= botoes;
      pronto_q     <= pronto_d;
      ganhou_q     <= ganhou_d;
      perdeu_q     <= perdeu_d;
      timeout_q    <= timeout_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[ptr_q] <= elem_novo;
  end

  always_comb begin
    leds = '0;
    if (estado_q == MOSTRA && !fase_q) begin
      leds = mem_q[k_q];
    end
`ifdef JOGO_ECO_EN
    else if (estado_q == ESPERA || estado_q == COMPARA) begin
      leds = botoes;
    end
`endif
  end

  assign pronto       = pronto_q;
  assign ganhou       = ganhou_q;
  assign perdeu       = perdeu_q;
  assign timeout      = timeout_q;
  assign rodada_atual = 7'(rodada_q);
  assign db_estado    = estado_q;

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Directed bench for jogo_sequencia_param: N=4, PROF=3, LED_CICLOS=2, TIMEOUT_CICLOS=8.
module tb_jogo_sequencia_param;
  localparam int N  = 4;
  localparam int P  = 3;
  localparam int TO = 8;
  localparam int LC = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         iniciar = 1'b0;
  logic [15:0]  semente = 16'h0000;
  logic [N-1:0] botoes = '0;
  logic [N-1:0] leds;
  logic         pronto, ganhou, perdeu, timeout;
  logic [6:0]   rodada_atual;
  logic [3:0]   db_estado;

  int checks = 0;
  int errors = 0;

  // Hand-computed: seed 0001 -> 0002,0004,0008 ; seed 0 -> ACE1 -> 59C3,B387,670F
  logic [N-1:0] seq_s1  [0:P-1] = '{4'b0100, 4'b0001, 4'b0001};
  logic [N-1:0] seq_ace [0:P-1] = '{4'b1000, 4'b1000, 4'b1000};
  logic [N-1:0] exp_seq [0:P-1];

  jogo_sequencia_param #(
    .N_BOTOES(N), .PROF(P), .TIMEOUT_CICLOS(TO), .LED_CICLOS(LC)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .semente(semente),
    .botoes(botoes), .leds(leds), .pronto(pronto), .ganhou(ganhou),
    .perdeu(perdeu), .timeout(timeout), .rodada_atual(rodada_atual),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_state(input logic [3:0] code, input int budget, output bit ok);
    int n;
    n  = 0;
    ok = (db_estado == code);
    while (!ok && n < budget) begin
      tick();
      n++;
      ok = (db_estado == code);
    end
  endtask

  task automatic start(input logic [15:0] s);
    semente = s;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  // Returns bad=-1 when the whole replay of round r matched exp_seq.
  task automatic show_round(input int r, output int bad, output logic [3:0] got, output logic [3:0] want);
    bit ok;
    bad  = -1;
    got  = '0;
    want = '0;
    wait_state(4'h2, 60, ok);
    if (!ok) begin
      bad = 999;
      got = db_estado;
      want = 4'h2;
      return;
    end
    for (int c = 0; c < 2*LC*(r+1); c++) begin
      want = ((c % (2*LC)) < LC) ? exp_seq[c/(2*LC)] : 4'b0000;
      if (db_estado !== 4'h2 || leds !== want) begin
        bad = c;
        got = leds;
        return;
      end
      tick();
    end
    if (db_estado !== 4'h3) begin
      bad  = 2*LC*(r+1);
      got  = db_estado;
      want = 4'h3;
    end
  endtask

  task automatic press(input logic [3:0] v, input int hold, output bit ok);
    wait_state(4'h3, 30, ok);
    if (!ok) return;
    botoes = v;
    repeat (hold) tick();
    botoes = '0;
    tick();
  endtask

  task automatic play_round(input int r, input string name);
    int bad;
    logic [3:0] got, want;
    bit ok;
    show_round(r, bad, got, want);
    checks++;
    if (bad != -1) begin
      errors++;
      $display("FAIL %s replay round %0d at cycle %0d: got %h want %h", name, r, bad, got, want);
    end
    for (int j = 0; j <= r; j++) begin
      press(exp_seq[j], 2, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s press round %0d jogada %0d: ESPERA not reached, estado %h", name, r, j, db_estado);
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({db_estado, leds, pronto, ganhou, perdeu, timeout, rodada_atual} !== '0) begin
      errors++;
      $display("FAIL reset_state: estado %h leds %b flags %b%b%b%b rodada %0d, want all 0",
               db_estado, leds, pronto, ganhou, perdeu, timeout, rodada_atual);
    end
    reset = 1'b1;
    tick();
    exp_seq = seq_s1;
    start(16'h0001);
    wait_state(4'h2, 20, ok);
    tick();
    checks++;
    if (db_estado !== 4'h2) begin
      errors++;
      $display("FAIL reset_mid_mostra_setup: estado %h want 2", db_estado);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({db_estado, leds, pronto, ganhou, perdeu, timeout, rodada_atual} !== '0) begin
      errors++;
      $display("FAIL reset_mid_mostra: estado %h leds %b flags %b%b%b%b, want all 0",
               db_estado, leds, pronto, ganhou, perdeu, timeout);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_win();
    int n;
    exp_seq = seq_s1;
    start(16'h0001);
    checks++;
    if (db_estado !== 4'h1) begin
      errors++;
      $display("FAIL win_start: estado %h want 1", db_estado);
    end
    n = 0;
    while (db_estado == 4'h1 && n < 20) begin
      n++;
      tick();
    end
    checks++;
    if (n != P || db_estado !== 4'h2) begin
      errors++;
      $display("FAIL win_gera_len: %0d cycles then estado %h, want %0d then 2", n, db_estado, P);
    end
    for (int r = 0; r < P; r++) play_round(r, "win");
    checks++;
    if (db_estado !== 4'hA || ganhou !== 1'b0 || pronto !== 1'b0) begin
      errors++;
      $display("FAIL win_entry: estado %h ganhou %b pronto %b, want A 0 0", db_estado, ganhou, pronto);
    end
    tick();
    checks++;
    if ({ganhou, pronto, perdeu, timeout} !== 4'b1100 || rodada_atual !== 7'd2 || leds !== '0) begin
      errors++;
      $display("FAIL win_flags: g/p/l/t %b%b%b%b rodada %0d leds %b, want 1100 2 0000",
               ganhou, pronto, perdeu, timeout, rodada_atual, leds);
    end
  endtask

  task automatic test_wrong_press();
    bit ok;
    int bad;
    logic [3:0] got, want;
    exp_seq = seq_s1;
    start(16'h0001);
    checks++;
    if (db_estado !== 4'h1 || ganhou !== 1'b0 || pronto !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear: estado %h ganhou %b pronto %b, want 1 0 0", db_estado, ganhou, pronto);
    end
    play_round(0, "erro");
    show_round(1, bad, got, want);
    checks++;
    if (bad != -1) begin
      errors++;
      $display("FAIL erro replay round 1 at cycle %0d: got %h want %h", bad, got, want);
    end
    press(4'b0100, 2, ok);
    press(4'b0010, 2, ok);
    checks++;
    if (db_estado !== 4'hE || {perdeu, ganhou, timeout, pronto} !== 4'b1001) begin
      errors++;
      $display("FAIL wrong_press: estado %h p/g/t/pr %b%b%b%b, want E 1001",
               db_estado, perdeu, ganhou, timeout, pronto);
    end
  endtask

  task automatic test_timeout();
    int bad, n;
    logic [3:0] got, want;
    exp_seq = seq_s1;
    start(16'h0001);
    checks++;
    if (db_estado !== 4'h1 || perdeu !== 1'b0) begin
      errors++;
      $display("FAIL restart_from_erro: estado %h perdeu %b, want 1 0", db_estado, perdeu);
    end
    show_round(0, bad, got, want);
    checks++;
    if (bad != -1) begin
      errors++;
      $display("FAIL same_seed_replay at cycle %0d: got %h want %h", bad, got, want);
    end
    n = 0;
    while (db_estado == 4'h3 && n < 20) begin
      n++;
      tick();
    end
    checks++;
    if (n != TO || db_estado !== 4'hD) begin
      errors++;
      $display("FAIL timeout_len: %0d cycles in ESPERA then estado %h, want %0d then D", n, db_estado, TO);
    end
    tick();
    checks++;
    if ({perdeu, timeout, pronto, ganhou} !== 4'b1110) begin
      errors++;
      $display("FAIL timeout_flags: p/t/pr/g %b%b%b%b, want 1110", perdeu, timeout, pronto, ganhou);
    end
  endtask

  task automatic test_multi_press();
    bit ok;
    int bad;
    logic [3:0] got, want;
    exp_seq = seq_s1;
    start(16'h0001);
    checks++;
    if (timeout !== 1'b0 || perdeu !== 1'b0) begin
      errors++;
      $display("FAIL restart_from_timeout: timeout %b perdeu %b, want 0 0", timeout, perdeu);
    end
    show_round(0, bad, got, want);
    press(4'b0011, 2, ok);
    checks++;
    if (db_estado !== 4'hE || perdeu !== 1'b1) begin
      errors++;
      $display("FAIL multi_press: estado %h perdeu %b, want E 1", db_estado, perdeu);
    end
  endtask

  task automatic test_held_button();
    bit ok;
    int bad;
    logic [3:0] got, want;
    exp_seq = seq_s1;
    start(16'h0001);
    play_round(0, "held");
    show_round(1, bad, got, want);
    wait_state(4'h3, 30, ok);
    botoes = 4'b0100;
    repeat (4) tick();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    checks++;
    if (db_estado !== 4'h5 || leds !== 4'b0000 || rodada_atual !== 7'd1) begin
      errors++;
      $display("FAIL held_button: estado %h leds %b rodada %0d, want 5 0000 1", db_estado, leds, rodada_atual);
    end
    botoes = '0;
    tick();
    checks++;
    if (db_estado !== 4'h3) begin
      errors++;
      $display("FAIL held_release: estado %h want 3", db_estado);
    end
    press(4'b0001, 2, ok);
    checks++;
    if (db_estado !== 4'h2 || rodada_atual !== 7'd2) begin
      errors++;
      $display("FAIL held_next_round: estado %h rodada %0d, want 2 2", db_estado, rodada_atual);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_zero_seed();
    bit ok;
    int bad;
    logic [3:0] got, want, eco;
`ifdef JOGO_ECO_EN
    eco = 4'b1000;
`else
    eco = 4'b0000;
`endif
    exp_seq = seq_ace;
    start(16'h0000);
    play_round(0, "seed0");
    show_round(1, bad, got, want);
    checks++;
    if (bad != -1) begin
      errors++;
      $display("FAIL seed0 replay round 1 at cycle %0d: got %h want %h", bad, got, want);
    end
    wait_state(4'h3, 30, ok);
    botoes = 4'b1000;
    tick();
    checks++;
    if (db_estado !== 4'h4 || leds !== eco) begin
      errors++;
      $display("FAIL echo_compara: estado %h leds %b, want 4 %b", db_estado, leds, eco);
    end
    tick();
    botoes = '0;
    tick();
    press(4'b1000, 2, ok);
    show_round(2, bad, got, want);
    checks++;
    if (bad != -1) begin
      errors++;
      $display("FAIL seed0 replay round 2 at cycle %0d: got %h want %h", bad, got, want);
    end
  endtask

  initial begin
    test_reset();
    test_win();
    test_wrong_press();
    test_timeout();
    test_multi_press();
    test_held_button();
    test_zero_seed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
